// File: rtl/uart_result_tx.sv
// uart_result_tx: sends "R<digit>\r\n" as 8N1 UART, or 8E1 when UART_RESULT_TX_PARITY_EN is defined
module uart_result_tx #(
    parameter int CLOCK_FREQ = 10_800_000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] result,
    output logic       busy,
    output logic       done,
    output logic       tx
);
    localparam int DIV = CLOCK_FREQ / BAUD_RATE;
    localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    generate
        if (DIV < 2) begin : g_div_check
            $error("uart_result_tx: CLOCK_FREQ/BAUD_RATE must be >= 2");
        end
    endgenerate
`ifdef UART_RESULT_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t        r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [2:0]    r_bit, w_bit;
    logic [1:0]    r_byte, w_byte;
    logic [3:0]    r_res, w_res;
    logic          r_tx, w_tx;
    logic          r_done, w_done;
    logic [7:0]    w_digit, w_cur;
    logic          w_wrap;
    assign w_digit = (r_res < 4'd10) ? 8'h30 + {4'h0, r_res} : 8'h3F;
    assign w_cur   = (r_byte == 2'd0) ? 8'h52 :
                     (r_byte == 2'd1) ? w_digit :
                     (r_byte == 2'd2) ? 8'h0D : 8'h0A;
    assign w_wrap  = r_cnt == LAST;
    // tx is registered from the next-state decision so the line never glitches
    always_comb begin
        w_state = r_state;
        w_cnt   = w_wrap ? '0 : r_cnt + 1'b1;
        w_bit   = r_bit;
        w_byte  = r_byte;
        w_res   = r_res;
        w_tx    = r_tx;
        w_done  = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt = '0;
                w_tx  = 1'b1;
                if (start) begin
                    w_state = START;
                    w_res   = result;
                    w_byte  = '0;
                    w_tx    = 1'b0;
                end
            end
            START: begin
                if (w_wrap) begin
                    w_state = DATA;
                    w_bit   = '0;
                    w_tx    = w_cur[0];
                end
            end
            DATA: begin
                if (w_wrap && r_bit == 3'd7) begin
`ifdef UART_RESULT_TX_PARITY_EN
                    w_state = PARITY;
                    w_tx    = ^w_cur;
`else
                    w_state = STOP;
                    w_tx    = 1'b1;
`endif
                end else if (w_wrap) begin
                    w_bit = r_bit + 3'd1;
                    w_tx  = w_cur[r_bit + 3'd1];
                end
            end
`ifdef UART_RESULT_TX_PARITY_EN
            PARITY: begin
                if (w_wrap) begin
                    w_state = STOP;
                    w_tx    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (w_wrap && r_byte == 2'd3) begin
                    w_state = IDLE;
                    w_done  = 1'b1;
                    w_tx    = 1'b1;
                end else if (w_wrap) begin
                    w_state = START;
                    w_byte  = r_byte + 2'd1;
                    w_tx    = 1'b0;
                end
            end
            default: w_state = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_res   <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_bit   <= w_bit;
            r_byte  <= w_byte;
            r_res   <= w_res;
            r_tx    <= w_tx;
            r_done  <= w_done;
        end
    end
    assign busy = r_state != IDLE;
    assign done = r_done;
    assign tx   = r_tx;
endmodule

// File: doc/uart_result_tx.md
Name: uart_result_tx

Overview:
UART transmitter stage placed downstream of the CNN result register in the UART controller. When the controller enters its RESULT step, it pulses start with the 4-bit class. The block sends a fixed 4-byte ASCII report to the host PC on the serial TX line: 'R', digit, CR, LF. It uses the same clock as uart_rx and the CNN (PLL output, 10.8 MHz).

Parameters:
CLOCK_FREQ, 10_800_000, clk frequency in Hz
BAUD_RATE, 9600, serial bit rate; DIV = CLOCK_FREQ/BAUD_RATE (integer division, 1125 at defaults); DIV >= 2 is required, otherwise elaboration error

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
start  input  1  single-cycle request to send a report; sampled only in IDLE
result  input  4  CNN class, latched on the accepted start
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse after the last stop bit of LF completes
tx  output  1  UART line, idle high

Behaviour:
- Reset (rst=1 at a clk edge):
  - tx=1, busy=0, done=0.
  - State IDLE; baud counter, bit index and byte index cleared.
  - Reset mid-frame aborts the transfer; tx is high from the next cycle.
- Frame format: 8N1, LSB first, each bit held exactly DIV cycles.
- Message bytes, in order:
  - byte0 = 0x52 'R'
  - byte1 = 0x30+result for result 0..9; 0x3F '?' for result 10..15
  - byte2 = 0x0D
  - byte3 = 0x0A
  - Digit is computed from the latched result, never the live port.
- FSM:
  - IDLE: tx=1. start=1 latches result, byte_idx=0, goes to START.
  - START: tx=0 for DIV cycles, then DATA with bit_idx=0.
  - DATA: tx=shift[0] for DIV cycles per bit. After bit 7, goes to STOP.
  - STOP: tx=1 for DIV cycles. Then:
    - byte_idx<3: byte_idx+1, back to START (no idle gap).
    - byte_idx==3: done=1 for one cycle, back to IDLE.
- Timing:
  - Accepted start at edge t: tx falls and busy rises at edge t+1.
  - Total message = 4*10*DIV cycles (45000 at defaults).
  - done asserts in the cycle busy drops.
  - A new start is accepted in the cycle after done, giving back-to-back messages.
- start while busy: ignored, and it does not queue.
- start in the same cycle as rst: rst wins.
- Baud counter counts 0..DIV-1 and wraps. The bit transition happens on the wrap.
- Counter width is $clog2(DIV). There is no free-running baud tick; the counter restarts at each accepted start.
- tx is driven from a flop (no combinational glitches).

Optional Feature:
Macro UART_RESULT_TX_PARITY_EN.
- Defined:
  - Frame becomes 8E1: an even-parity bit (XOR of the 8 data bits) goes between bit 7 and stop, held DIV cycles, via an extra state PARITY.
  - Message length = 4*11*DIV cycles.
- Undefined:
  - 8N1 as above; no PARITY state or logic is synthesized.

Test Plan:
- Reset then idle, CLOCK_FREQ=16, BAUD_RATE=1 (DIV=16), 200 cycles with no start → tx=1, busy=0, done=0 throughout.
- start with result=5 (DIV=16) → tx low at t+1. Bench UART decodes 0x52,0x35,0x0D,0x0A. Each bit lasts 16 cycles. done pulses exactly 640 cycles after t+1. busy is high for those 640 cycles.
- start with result=12 → byte1 decodes as 0x3F. Change result to 3 during transmission → bytes unchanged.
- start pulsed again at cycle t+100 while busy → ignored: only one message, done once. A second start in the cycle after done → second message begins with no gap.
- rst asserted mid byte1 data bit 4 → next cycle tx=1, busy=0, no done. A following start with result=0 sends a full clean message 'R','0',CR,LF.
- With UART_RESULT_TX_PARITY_EN defined, result=7 → byte1 0x37 carries parity bit 1, byte0 0x52 carries parity bit 1. done arrives 704 cycles after t+1.
